// File: rtl/ms_tick_counter.sv
// rtl/ms_tick_counter.sv - millisecond timebase: prescaled tick pulse and elapsed-tick counter
//
// Divides clk by DIV = CLK_FREQ_HZ / TICK_HZ and produces a one-cycle tick_out
// every DIV enabled cycles, together with a free-running count of ticks.
//
// Optional feature macro: MS_COUNTER_ALARM_EN (adds alarm_ms / alarm_out).
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-high reset
//   en         count enable; the prescaler advances only while high
//   clear      synchronous clear of prescaler, ms_count, tick_out (and alarm_out)
//   tick_out   one-cycle tick pulse, registered
//   ms_count   elapsed ticks since reset/clear, registered, wraps silently
//   alarm_ms   (MS_COUNTER_ALARM_EN) tick count that raises alarm_out
//   alarm_out  (MS_COUNTER_ALARM_EN) one-cycle pulse when ms_count steps onto alarm_ms

module ms_tick_counter #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int TICK_HZ     = 1000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
`ifdef MS_COUNTER_ALARM_EN
    input  logic [CNT_W-1:0] alarm_ms,
    output logic             alarm_out,
`endif
    output logic             tick_out,
    output logic [CNT_W-1:0] ms_count
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("ms_tick_counter: CLK_FREQ_HZ / TICK_HZ must be at least 2");
        end
    endgenerate

    logic [PW-1:0]    prescaler;
    logic             terminal;
    logic [CNT_W-1:0] ms_count_inc;

    assign terminal     = en && (prescaler == LAST);
    assign ms_count_inc = ms_count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler <= '0;
            ms_count  <= '0;
            tick_out  <= 1'b0;
        end else if (clear) begin
            prescaler <= '0;
            ms_count  <= '0;
            tick_out  <= 1'b0;
        end else if (terminal) begin
            prescaler <= '0;
            ms_count  <= ms_count_inc;
            tick_out  <= 1'b1;
        end else if (en) begin
            prescaler <= prescaler + 1'b1;
            tick_out  <= 1'b0;
        end else begin
            // Paused: prescaler keeps its phase so the period resumes where it stopped.
            tick_out  <= 1'b0;
        end
    end

`ifdef MS_COUNTER_ALARM_EN
    // Compared against the post-increment value so the alarm lands on the same
    // edge that makes ms_count equal alarm_ms; alarm_ms is only looked at then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_out <= 1'b0;
        end else if (clear) begin
            alarm_out <= 1'b0;
        end else begin
            alarm_out <= terminal && (ms_count_inc == alarm_ms);
        end
    end
`endif

endmodule

// File: tb/tb_ms_tick_counter.sv
// tb/tb_ms_tick_counter.sv - directed self-checking bench for ms_tick_counter

module tb_ms_tick_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clear = 1'b0;
    logic        tick_a;
    logic [31:0] count_a;
    logic        tick_b;
    logic [3:0]  count_b;
`ifdef MS_COUNTER_ALARM_EN
    logic [31:0] alarm_ms_a = 32'd3;
    logic [3:0]  alarm_ms_b = 4'd0;
    logic        alarm_a;
    logic        alarm_b;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // DIV = 10, 32-bit counter
    ms_tick_counter #(.CLK_FREQ_HZ(10000), .TICK_HZ(1000), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
`ifdef MS_COUNTER_ALARM_EN
        .alarm_ms(alarm_ms_a), .alarm_out(alarm_a),
`endif
        .tick_out(tick_a), .ms_count(count_a)
    );

    // DIV = 2, 4-bit counter for wrap checks
    ms_tick_counter #(.CLK_FREQ_HZ(2000), .TICK_HZ(1000), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .clear(clear),
`ifdef MS_COUNTER_ALARM_EN
        .alarm_ms(alarm_ms_b), .alarm_out(alarm_b),
`endif
        .tick_out(tick_b), .ms_count(count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit later.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b1;
        clear = 1'b0;
        step(3);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset and basic period
        step(3);
        check("reset_tick", {31'd0, tick_a}, 32'd0);
        check("reset_count", count_a, 32'd0);
        rst = 1'b0;
        en = 1'b1;
        step(9);
        check("t1_pre_tick", {31'd0, tick_a}, 32'd0);
        check("t1_pre_count", count_a, 32'd0);
        step(1);
        check("t1_tick10", {31'd0, tick_a}, 32'd1);
        check("t1_count10", count_a, 32'd1);
        step(1);
        check("t1_tick11", {31'd0, tick_a}, 32'd0);
        step(8);
        check("t1_tick19", {31'd0, tick_a}, 32'd0);
        step(1);
        check("t1_tick20", {31'd0, tick_a}, 32'd1);
        check("t1_count20", count_a, 32'd2);
        step(10);
        check("t1_tick30", {31'd0, tick_a}, 32'd1);
        check("t1_count30", count_a, 32'd3);

        // 2. Enable gating preserves phase
        do_reset();
        step(4);
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step(1);
            check("t2_paused_tick", {31'd0, tick_a}, 32'd0);
        end
        check("t2_paused_count", count_a, 32'd0);
        en = 1'b1;
        step(5);
        check("t2_tick5", {31'd0, tick_a}, 32'd0);
        step(1);
        check("t2_tick6", {31'd0, tick_a}, 32'd1);
        check("t2_count6", count_a, 32'd1);

        // 3. Clear mid-period and on the terminal cycle
        do_reset();
        step(50);
        check("t3_count5", count_a, 32'd5);
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t3_clr_count", count_a, 32'd0);
        check("t3_clr_tick", {31'd0, tick_a}, 32'd0);
        step(9);
        check("t3_post9", {31'd0, tick_a}, 32'd0);
        step(1);
        check("t3_post10", {31'd0, tick_a}, 32'd1);
        check("t3_post10_count", count_a, 32'd1);
        step(9);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        check("t3_term_tick", {31'd0, tick_a}, 32'd0);
        check("t3_term_count", count_a, 32'd0);
        step(9);
        check("t3_term_post9", {31'd0, tick_a}, 32'd0);
        step(1);
        check("t3_term_post10", {31'd0, tick_a}, 32'd1);

        // 4. Wrap on the 4-bit, DIV=2 instance
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check("t4_gap_tick", {31'd0, tick_b}, 32'd0);
            step(1);
            check("t4_tick", {31'd0, tick_b}, 32'd1);
            check("t4_count", {28'd0, count_b}, 32'(i % 16));
        end
        step(2);
        check("t4_after_wrap", {28'd0, count_b}, 32'd1);

        // 5. Asynchronous reset between edges
        do_reset();
        step(27);
        check("t5_count_pre", count_a, 32'd2);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_tick", {31'd0, tick_a}, 32'd0);
        check("t5_async_count", count_a, 32'd0);
        check("t5_async_pre", {28'd0, u_dut_a.prescaler}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(9);
        check("t5_restart9", {31'd0, tick_a}, 32'd0);
        step(1);
        check("t5_restart10", {31'd0, tick_a}, 32'd1);
        check("t5_restart_count", count_a, 32'd1);

`ifdef MS_COUNTER_ALARM_EN
        // 6. Alarm on ms_count reaching alarm_ms, and at wrap with alarm_ms = 0
        do_reset();
        for (int e = 1; e <= 40; e++) begin
            step(1);
            check("t6_alarm_a", {31'd0, alarm_a}, (e == 30) ? 32'd1 : 32'd0);
            check("t6_alarm_b", {31'd0, alarm_b}, (e == 32) ? 32'd1 : 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
